// File: rtl/wshb_arb_pkg.sv
// wshb_arb_pkg: shared state type, sizing limits and rotating-priority helper for the Wishbone arbiter.
package wshb_arb_pkg;
    localparam int MAX_NM = 8;
    localparam int MAX_LW = $clog2(MAX_NM);

    typedef enum logic {IDLE, GRANT} arb_state_t;

    // One-hot pick of the first set bit of req scanning last+1, last+2, ... modulo n.
    function automatic logic [MAX_NM-1:0] rr_pick(
        input logic [MAX_NM-1:0] req,
        input int                last,
        input int                n
    );
        logic [MAX_NM-1:0] pick;
        logic [MAX_LW-1:0] idx;
        logic              found;
        pick  = '0;
        found = 1'b0;
        for (int k = 1; k <= MAX_NM; k++) begin
            idx = MAX_LW'((last + k) % n);
            if (k <= n && !found && req[idx]) begin
                pick[idx] = 1'b1;
                found     = 1'b1;
            end
        end
        return pick;
    endfunction
endpackage

// File: rtl/wshb_rr_pick.sv
// wshb_rr_pick: combinational rotating-priority encoder; the first requester after index last wins.
module wshb_rr_pick
    import wshb_arb_pkg::*;
#(
    parameter int NM = 2
) (
    input  logic [NM-1:0]         req,
    input  logic [$clog2(NM)-1:0] last,
    output logic [NM-1:0]         gnt_next,
    output logic                  valid
);
    logic [MAX_NM-1:0] pick;

    assign pick     = rr_pick(MAX_NM'(req), int'(last), NM);
    assign gnt_next = pick[NM-1:0];
    assign valid    = |pick;
endmodule

// File: rtl/wshb_rr_arbiter.sv
// wshb_rr_arbiter: NM-master to 1-slave Wishbone B4 classic interconnect with round-robin grant per cyc span.
// Define WSHB_ARB_TIMEOUT_EN to add a watchdog that errors out an owner stalled by the slave for TIMEOUT cycles.
module wshb_rr_arbiter
    import wshb_arb_pkg::*;
#(
    parameter int NM      = 2,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 1023
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NM-1:0]      m_cyc,
    input  logic [NM-1:0]      m_stb,
    input  logic [NM-1:0]      m_we,
    input  logic [NM*DW/8-1:0] m_sel,
    input  logic [NM*AW-1:0]   m_adr,
    input  logic [NM*DW-1:0]   m_dat_w,
    output logic [DW-1:0]      m_dat_r,
    output logic [NM-1:0]      m_ack,
    output logic [NM-1:0]      m_err,
    output logic               s_cyc,
    output logic               s_stb,
    output logic               s_we,
    output logic [DW/8-1:0]    s_sel,
    output logic [AW-1:0]      s_adr,
    output logic [DW-1:0]      s_dat_w,
    input  logic [DW-1:0]      s_dat_r,
    input  logic               s_ack,
    input  logic               s_err,
    output logic [NM-1:0]      gnt
);
    localparam int SW = DW / 8;
    localparam int LW = $clog2(NM);

    arb_state_t    state, state_n;
    logic [NM-1:0] gnt_n, pick;
    logic [LW-1:0] last, last_n, pick_idx;
    logic          pick_valid, cyc_g, stb_g, to_hit;

    if (NM < 2 || NM > MAX_NM || DW % 8 != 0 || TIMEOUT < 1) begin : g_bad_params
        $error("wshb_rr_arbiter: illegal parameter set");
    end

    wshb_rr_pick #(.NM(NM)) u_pick (
        .req      (m_cyc),
        .last     (last),
        .gnt_next (pick),
        .valid    (pick_valid)
    );

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < NM; i++)
            if (pick[i]) pick_idx = LW'(i);
    end

    // AND-OR mux relies on gnt being one-hot or zero, so an idle bus drives all zeros.
    always_comb begin
        cyc_g   = 1'b0;
        stb_g   = 1'b0;
        s_we    = 1'b0;
        s_sel   = '0;
        s_adr   = '0;
        s_dat_w = '0;
        for (int i = 0; i < NM; i++) begin
            cyc_g   = cyc_g | (gnt[i] & m_cyc[i]);
            stb_g   = stb_g | (gnt[i] & m_stb[i]);
            s_we    = s_we  | (gnt[i] & m_we[i]);
            s_sel   = s_sel   | ({SW{gnt[i]}} & m_sel[i*SW +: SW]);
            s_adr   = s_adr   | ({AW{gnt[i]}} & m_adr[i*AW +: AW]);
            s_dat_w = s_dat_w | ({DW{gnt[i]}} & m_dat_w[i*DW +: DW]);
        end
    end

    assign s_cyc   = cyc_g & ~to_hit;
    assign s_stb   = stb_g;
    assign m_dat_r = s_dat_r;
    assign m_ack   = {NM{s_ack}} & gnt;
    assign m_err   = {NM{s_err | to_hit}} & gnt;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= IDLE;
            gnt   <= '0;
            last  <= LW'(NM - 1);
        end else begin
            state <= state_n;
            gnt   <= gnt_n;
            last  <= last_n;
        end

    // last doubles as the granted index while in GRANT.
    always_comb begin
        state_n = state;
        gnt_n   = gnt;
        last_n  = last;
        if (state == IDLE) begin
            if (pick_valid) begin
                state_n = GRANT;
                gnt_n   = pick;
                last_n  = pick_idx;
            end
        end else if (!cyc_g || to_hit) begin
            state_n = IDLE;
            gnt_n   = '0;
        end
    end

`ifdef WSHB_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] to_cnt;
    logic          stall, timeout_seen;

    assign stall  = cyc_g & stb_g & ~s_ack & ~s_err;
    assign to_hit = (state == GRANT) && stall && (to_cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            to_cnt       <= '0;
            timeout_seen <= 1'b0;
        end else begin
            to_cnt       <= (state != GRANT || s_ack || s_err) ? '0 : stall ? to_cnt + CW'(1) : to_cnt;
            timeout_seen <= timeout_seen | to_hit;
        end
`else
    assign to_hit = 1'b0;
`endif
endmodule
